// File: rtl/irq_pkg.sv
// irq_pkg: shared sizes, FSM state type and mask reset value for irq_ctrl8.
package irq_pkg;
  localparam int NUM_IRQ = 8;
  localparam int ID_W    = 3;
  typedef enum logic [1:0] {IDLE, PEND, SERVICE} irq_state_t;
  localparam logic [NUM_IRQ-1:0] MASK_RST = 8'hFF;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: 2-flop synchronizer plus previous-level flop for one request line; emits level and rise pulse.
module irq_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);
  logic sync1_q, sync2_q, prev_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {sync1_q, sync2_q, prev_q} <= '0;
    else        {sync1_q, sync2_q, prev_q} <= {d_i, sync1_q, sync2_q};
  assign level_o = sync2_q;
  assign rise_o  = sync2_q & ~prev_q;
endmodule

// File: rtl/irq_ctrl8.sv
// irq_ctrl8: 8-line interrupt front end with pending/mask and single-level ack/eoi handshake.
// Define IRQ_LEVEL_EN for level-sensitive pending (pending follows the synchronized line).
module irq_ctrl8 import irq_pkg::*; (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  output logic [NUM_IRQ-1:0] req_out,
  input  logic [ID_W-1:0]    grant_id,
  input  logic               grant_valid,
  output logic               irq_o,
  input  logic               ack_i,
  output logic [ID_W-1:0]    active_id,
  output logic               in_service,
  input  logic               eoi_i
);
  logic [NUM_IRQ-1:0] level, rise, pending, mask_q;
  irq_state_t state_q;
  logic irq_q, svc_q, ack_ok;
  logic [ID_W-1:0] aid_q;
  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    irq_sync u_sync (.clk(clk), .rst_n(rst_n), .d_i(irq_in[g]), .level_o(level[g]), .rise_o(rise[g]));
  end
  // An ack only counts while the encoder still presents a winner.
  assign ack_ok = (state_q == PEND) && grant_valid && ack_i;
`ifdef IRQ_LEVEL_EN
  logic unused_rise;
  assign unused_rise = ^rise;
  assign pending     = level;
`else
  logic [NUM_IRQ-1:0] pend_q, clr;
  logic unused_level;
  assign unused_level = ^level;
  assign clr = ack_ok ? {{(NUM_IRQ-1){1'b0}}, 1'b1} << grant_id : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= '0;
    else        pend_q <= (pend_q & ~clr) | rise;
  assign pending = pend_q;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       mask_q <= MASK_RST;
    else if (mask_we) mask_q <= mask_wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
      svc_q   <= 1'b0;
      aid_q   <= '0;
    end else begin
      case (state_q)
        IDLE:    if (grant_valid) begin
                   state_q <= PEND;
                   irq_q   <= 1'b1;
                 end
        PEND:    if (!grant_valid) begin
                   state_q <= IDLE;
                   irq_q   <= 1'b0;
                 end else if (ack_ok) begin
                   state_q <= SERVICE;
                   irq_q   <= 1'b0;
                   svc_q   <= 1'b1;
                   aid_q   <= grant_id;
                 end
        SERVICE: if (eoi_i) begin
                   state_q <= IDLE;
                   svc_q   <= 1'b0;
                 end
        default: begin
                   state_q <= IDLE;
                   irq_q   <= 1'b0;
                   svc_q   <= 1'b0;
                 end
      endcase
    end
  assign req_out    = pending & ~mask_q;
  assign irq_o      = irq_q;
  assign in_service = svc_q;
  assign active_id  = aid_q;
endmodule
